// File: rtl/avlstrm_pkt_dropper.sv
// avlstrm_pkt_dropper: whole-packet forward/drop stage feeding a packet FIFO through a 2-entry skid buffer.
// Define PKT_DROPPER_STATS_EN to build the packet/drop/error statistics counters (tied to zero otherwise).
module avlstrm_pkt_dropper #(
    parameter int DATA_WIDTH  = 512,
    parameter int EMPTY_WIDTH = 6
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [EMPTY_WIDTH-1:0] in_empty,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    output logic                   out_sop,
    output logic                   out_eop,
    output logic [EMPTY_WIDTH-1:0] out_empty,
    input  logic                   out_ready,
    input  logic                   out_almost_full,
    output logic [31:0]            stats_pkt_in,
    output logic [31:0]            stats_pkt_drop,
    output logic [31:0]            stats_flit_drop,
    output logic [31:0]            stats_err
);
    localparam int FW = DATA_WIDTH + EMPTY_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, PASS, DROP} state_t;

    state_t          r_state, w_state_nxt;
    logic [FW-1:0]   r_d0, r_d1;
    logic [1:0]      r_cnt, w_cnt_nxt;
    logic            r_in_ready;
    logic            w_acc, w_fwd, w_pop, w_ld0, w_ld1;
    logic [FW-1:0]   w_flit;

    // DROP never pushes into the buffer, so it can accept at line rate regardless of occupancy
    assign in_ready = r_in_ready || (r_state == DROP);
    assign w_acc    = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;
    assign w_flit   = {in_sop, in_eop, in_empty, in_data};

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = 1'b0;
        if (w_acc) begin
            unique case (r_state)
                IDLE: if (in_sop) begin
                    w_fwd       = !out_almost_full;
                    w_state_nxt = in_eop ? IDLE : (out_almost_full ? DROP : PASS);
                end
                PASS: begin
                    w_fwd       = !in_sop;
                    w_state_nxt = (!in_sop && in_eop) ? IDLE : PASS;
                end
                DROP:    w_state_nxt = in_eop ? IDLE : DROP;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // r_d0 is the head driving out_*, r_d1 holds the second entry when the FIFO stalls
    assign w_cnt_nxt = r_cnt + {1'b0, w_fwd} - {1'b0, w_pop};
    assign w_ld0     = (w_pop && (r_cnt == 2'd2 || w_fwd)) || (w_fwd && r_cnt == 2'd0);
    assign w_ld1     = w_fwd && (r_cnt == 2'd2 || (r_cnt == 2'd1 && !w_pop));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt      <= '0;
            r_d0       <= '0;
            r_d1       <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= w_cnt_nxt != 2'd2;
            if (w_ld0) r_d0 <= (r_cnt == 2'd2) ? r_d1 : w_flit;
            if (w_ld1) r_d1 <= w_flit;
        end
    end

    assign out_valid = r_cnt != 2'd0;
    assign {out_sop, out_eop, out_empty, out_data} = r_d0;

`ifdef PKT_DROPPER_STATS_EN
    logic [31:0] r_pkt_in, r_pkt_drop, r_flit_drop, r_err;
    logic        w_idle_sop, w_err;

    assign w_idle_sop = w_acc && (r_state == IDLE) && in_sop;
    // a packet-framing error is a missing sop in IDLE or a stray sop inside a packet
    assign w_err      = w_acc && ((r_state == IDLE) != in_sop);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pkt_in    <= '0;
            r_pkt_drop  <= '0;
            r_flit_drop <= '0;
            r_err       <= '0;
        end else begin
            r_pkt_in    <= r_pkt_in + {31'd0, w_idle_sop};
            r_pkt_drop  <= r_pkt_drop + {31'd0, w_idle_sop && out_almost_full};
            r_flit_drop <= r_flit_drop + {31'd0, w_acc && !w_fwd};
            r_err       <= r_err + {31'd0, w_err};
        end
    end

    assign stats_pkt_in    = r_pkt_in;
    assign stats_pkt_drop  = r_pkt_drop;
    assign stats_flit_drop = r_flit_drop;
    assign stats_err       = r_err;
`else
    assign stats_pkt_in    = '0;
    assign stats_pkt_drop  = '0;
    assign stats_flit_drop = '0;
    assign stats_err       = '0;
`endif
endmodule
